// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Detects load-use hazards between the load in EX and the instruction in ID,
// inserts the configured number of bubbles, flushes IF/ID on a taken branch,
// freezes everything while data memory is busy, and keeps a saturating count
// of cycles in which the PC did not advance.

module pipeline_hazard_ctrl #(
  parameter int S                 = 32,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [S-1:0]     id_inst,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN,
    LDSTALL
  } state_t;

  // Bubbles still owed after the first stall cycle, which is spent in RUN.
  localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL_CYCLES - 1);

  // Opcodes whose rt field is read rather than written: R-type, beq, bne, sw.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     state, next_state;
  logic [1:0] cnt, next_cnt;

  logic [5:0] opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       rt_is_src;
  logic       load_use;

  assign opcode = id_inst[31:26];
  assign id_rs  = id_inst[25:21];
  assign id_rt  = id_inst[20:16];

  // Field decode and load-use detection; a load into $zero never creates a dependency.
  always_comb begin
    rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                (opcode == OP_BNE)   || (opcode == OP_SW);
    load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_is_src));
  end

  // Control outputs and next state, resolved in priority order: reset, freeze, branch, hazard.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves one unassigned and infers a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    next_state   = state;
    next_cnt     = cnt;

    if (!reset) begin
      // Let the pipeline registers clear while the PC is held.
      pc_write     = 1'b0;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      next_state   = RUN;
      next_cnt     = 2'd0;
    end else if (dmem_busy) begin
      // Whole pipeline frozen; state and bubble count are held.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            // Wrong-path instructions in IF/ID and ID are squashed; any hazard they raised is moot.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              next_state = LDSTALL;
              next_cnt   = CNT_INIT;
            end
          end
        end
        LDSTALL: begin
          // Extra bubbles are unconditional: the load is no longer in EX to re-trigger detection.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          if_id_flush  = 1'b0;
          id_ex_bubble = 1'b1;
          next_cnt     = cnt - 2'd1;
          if (cnt == 2'd1) begin
            next_state = RUN;
          end
        end
        default: begin
          next_state = RUN;
          next_cnt   = 2'd0;
        end
      endcase
    end
  end

  // State, bubble counter and saturating stall counter, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state        <= RUN;
      cnt          <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share one stimulus
// stream: one with a single load-use bubble, one with three. Control outputs
// are checked mid-cycle against hand-written vectors; stall counters are
// checked after each edge against a small saturating model.

module tb_pipeline_hazard_ctrl;

  // Output vectors ordered {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
  localparam logic [3:0] O_RST = 4'b0111;
  localparam logic [3:0] O_FRZ = 4'b0000;
  localparam logic [3:0] O_BR  = 4'b1111;
  localparam logic [3:0] O_STL = 4'b0001;
  localparam logic [3:0] O_RUN = 4'b1100;

  localparam logic [31:0] I_ADD_R5 = 32'h00A21820; // add $3,$5,$2 : rs=5
  localparam logic [31:0] I_ADD_R0 = 32'h00001820; // add $3,$0,$0 : rs=0
  localparam logic [31:0] I_ADDI   = 32'h20250004; // addi $5,$1,4 : rt=5 destination
  localparam logic [31:0] I_LW     = 32'h8C250000; // lw $5,0($1)  : rt=5 destination
  localparam logic [31:0] I_SW     = 32'hAC250000; // sw $5,0($1)  : rt=5 source
  localparam logic [31:0] I_BEQ    = 32'h10250000; // beq $1,$5    : rt=5 source
  localparam logic [31:0] I_NOP    = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_inst;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        dmem_busy;

  logic        pw1, iw1, fl1, bb1;
  logic        pw3, iw3, fl3, bb3;
  logic [15:0] sc1, sc3;
  logic [3:0]  o1, o3;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] m1 = '0;
  logic [15:0] m3 = '0;

  assign o1 = {pw1, iw1, fl1, bb1};
  assign o3 = {pw3, iw3, fl3, bb3};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.S(32), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_inst(id_inst), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pw1), .if_id_write(iw1), .if_id_flush(fl1), .id_ex_bubble(bb1),
    .stall_cycles(sc1)
  );

  pipeline_hazard_ctrl #(.S(32), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .id_inst(id_inst), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pw3), .if_id_write(iw3), .if_id_flush(fl3), .id_ex_bubble(bb3),
    .stall_cycles(sc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic mr, input logic [4:0] rt,
                       input logic [31:0] inst, input logic br, input logic busy);
    reset        = rst;
    ex_mem_read  = mr;
    ex_rt        = rt;
    id_inst      = inst;
    branch_taken = br;
    dmem_busy    = busy;
  endtask

  // One clock: check outputs mid-cycle, advance the counter model, check counters after the edge.
  task automatic cycle(input string tag, input logic [3:0] x1, input logic [3:0] x3);
    #1;
    chk({tag, "/out_lsc1"}, 32'(o1), 32'(x1));
    chk({tag, "/out_lsc3"}, 32'(o3), 32'(x3));
    if (!reset) begin
      m1 = '0;
      m3 = '0;
    end else begin
      if (!x1[3] && m1 != 16'hFFFF) m1 = m1 + 16'd1;
      if (!x3[3] && m3 != 16'hFFFF) m3 = m3 + 16'd1;
    end
    @(posedge clk);
    #1;
    chk({tag, "/cnt_lsc1"}, 32'(sc1), 32'(m1));
    chk({tag, "/cnt_lsc3"}, 32'(sc3), 32'(m3));
  endtask

  initial begin
    // Reset dominates busy and branch.
    drive(1'b0, 1'b0, 5'd0, I_NOP, 1'b1, 1'b1);
    cycle("rst_busy", O_RST, O_RST);
    drive(1'b0, 1'b0, 5'd0, I_NOP, 1'b0, 1'b0);
    cycle("rst_idle", O_RST, O_RST);
    drive(1'b1, 1'b0, 5'd0, I_NOP, 1'b0, 1'b0);
    cycle("run_idle", O_RUN, O_RUN);

    // Load-use on rs: one bubble vs three; LDSTALL ignores branch and a fresh hazard.
    drive(1'b1, 1'b1, 5'd5, I_ADD_R5, 1'b0, 1'b0);
    cycle("lu_rs", O_STL, O_STL);
    drive(1'b1, 1'b0, 5'd0, I_ADD_R5, 1'b1, 1'b0);
    cycle("lu_br_in_ldstall", O_BR, O_STL);
    drive(1'b1, 1'b1, 5'd5, I_ADD_R5, 1'b0, 1'b0);
    cycle("lu_haz_in_ldstall", O_STL, O_STL);
    drive(1'b1, 1'b0, 5'd0, I_ADD_R5, 1'b0, 1'b0);
    cycle("lu_done", O_RUN, O_RUN);

    // No stall: load into $zero, and rt written (not read) by addi / lw.
    drive(1'b1, 1'b1, 5'd0, I_ADD_R0, 1'b0, 1'b0);
    cycle("rt_zero", O_RUN, O_RUN);
    drive(1'b1, 1'b1, 5'd5, I_ADDI, 1'b0, 1'b0);
    cycle("addi_dest", O_RUN, O_RUN);
    drive(1'b1, 1'b1, 5'd5, I_LW, 1'b0, 1'b0);
    cycle("lw_dest", O_RUN, O_RUN);

    // Stall on rt as a source: sw, then beq, each drained.
    drive(1'b1, 1'b1, 5'd5, I_SW, 1'b0, 1'b0);
    cycle("sw_src", O_STL, O_STL);
    drive(1'b1, 1'b0, 5'd0, I_NOP, 1'b0, 1'b0);
    cycle("sw_drain1", O_RUN, O_STL);
    cycle("sw_drain2", O_RUN, O_STL);
    drive(1'b1, 1'b1, 5'd5, I_BEQ, 1'b0, 1'b0);
    cycle("beq_src", O_STL, O_STL);
    drive(1'b1, 1'b0, 5'd0, I_NOP, 1'b0, 1'b0);
    cycle("beq_drain1", O_RUN, O_STL);
    cycle("beq_drain2", O_RUN, O_STL);
    cycle("beq_run", O_RUN, O_RUN);

    // Branch beats a simultaneous hazard.
    drive(1'b1, 1'b1, 5'd5, I_ADD_R5, 1'b1, 1'b0);
    cycle("br_over_haz", O_BR, O_BR);
    drive(1'b1, 1'b0, 5'd0, I_NOP, 1'b0, 1'b0);
    cycle("br_after", O_RUN, O_RUN);

    // Freeze for 4 cycles mid-LDSTALL; remaining two bubbles follow.
    drive(1'b1, 1'b1, 5'd5, I_ADD_R5, 1'b0, 1'b0);
    cycle("frz_haz", O_STL, O_STL);
    drive(1'b1, 1'b0, 5'd0, I_ADD_R5, 1'b0, 1'b1);
    cycle("frz1", O_FRZ, O_FRZ);
    cycle("frz2", O_FRZ, O_FRZ);
    drive(1'b1, 1'b1, 5'd5, I_ADD_R5, 1'b1, 1'b1);
    cycle("frz3_br_haz", O_FRZ, O_FRZ);
    drive(1'b1, 1'b0, 5'd0, I_ADD_R5, 1'b0, 1'b1);
    cycle("frz4", O_FRZ, O_FRZ);
    drive(1'b1, 1'b0, 5'd0, I_ADD_R5, 1'b0, 1'b0);
    cycle("frz_rest1", O_RUN, O_STL);
    cycle("frz_rest2", O_RUN, O_STL);
    cycle("frz_run", O_RUN, O_RUN);

    // Reset mid-LDSTALL and during a freeze.
    drive(1'b1, 1'b1, 5'd5, I_ADD_R5, 1'b0, 1'b0);
    cycle("rst_haz", O_STL, O_STL);
    drive(1'b0, 1'b1, 5'd5, I_ADD_R5, 1'b0, 1'b0);
    cycle("rst_mid_ldstall", O_RST, O_RST);
    drive(1'b1, 1'b0, 5'd0, I_NOP, 1'b0, 1'b0);
    cycle("rst_back_run", O_RUN, O_RUN);
    drive(1'b0, 1'b0, 5'd0, I_NOP, 1'b0, 1'b1);
    cycle("rst_in_busy", O_RST, O_RST);
    drive(1'b1, 1'b0, 5'd0, I_NOP, 1'b0, 1'b0);
    cycle("rst_busy_run", O_RUN, O_RUN);

    // Saturation: 65534 frozen cycles reach 0xFFFE, three more stop at 0xFFFF.
    drive(1'b1, 1'b0, 5'd0, I_NOP, 1'b0, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    m1 = 16'hFFFE;
    m3 = 16'hFFFE;
    chk("sat_pre_lsc1", 32'(sc1), 32'(m1));
    chk("sat_pre_lsc3", 32'(sc3), 32'(m3));
    cycle("sat1", O_FRZ, O_FRZ);
    cycle("sat2", O_FRZ, O_FRZ);
    cycle("sat3", O_FRZ, O_FRZ);
    chk("sat_final", 32'(sc1), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
